// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multiport register file.
// No logic; pure type and parameter definitions.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int ZERO_ADDR      = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then parks in READY.
// Latency: busy for exactly 2**ADDR_W cycles after reset release; no backpressure.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_en    = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                // The last entry is cleared on the same edge that leaves CLEAR.
                if (cnt == '1) begin
                    cnt_nxt   = '0;
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_multiport.sv
// Two-read/one-write register file with sequenced clear, optional bypass and zero register.
// Latency: 1 cycle read; writes visible after the write edge; writes dropped (and flagged) while busy.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_dropped
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_hit_zero;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_nxt_a;
    logic [DATA_W-1:0] rd_nxt_b;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_hit_zero = ZERO_REG && (wr_addr == ZERO_A);
    assign wr_ok       = wr_en && !reset && !busy && !wr_hit_zero;

    // clr_en and wr_ok never overlap: user writes are blocked while busy.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_nxt_a = mem[rd_addr_a];
        rd_nxt_b = mem[rd_addr_b];
        if (BYPASS && wr_ok && (rd_addr_a == wr_addr)) begin
            rd_nxt_a = wr_data;
        end
        if (BYPASS && wr_ok && (rd_addr_b == wr_addr)) begin
            rd_nxt_b = wr_data;
        end
        // Zero masking wins over bypass.
        if (ZERO_REG && (rd_addr_a == ZERO_A)) begin
            rd_nxt_a = '0;
        end
        if (ZERO_REG && (rd_addr_b == ZERO_A)) begin
            rd_nxt_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= wr_en && (busy || wr_hit_zero);
            if (busy) begin
                rd_data_a <= '0;
                rd_data_b <= '0;
            end else begin
                rd_data_a <= rd_nxt_a;
                rd_data_b <= rd_nxt_b;
            end
        end
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file used by the datapath.
- Adds configurable width and depth, synchronous reset with a sequenced clear of every entry, and optional write-to-read bypass.
- Adds an optional hardwired-zero register 0 and a busy/ready indication.
- Sits between decode (register addresses) and the ALU (operands); the writeback stage drives the write port.

Parameters:
- DATA_W, 16, width of each register entry in bits
- ADDR_W, 4, address width; depth is 2**ADDR_W entries
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new data; 0 = it returns the old data
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are dropped

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  DATA_W  registered read data, port A
- rd_data_b  output  DATA_W  registered read data, port B
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- busy  output  1  high while the post-reset clear sequence runs
- wr_dropped  output  1  registered one-cycle pulse: a write was ignored because of busy or ZERO_REG

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. Sampled only on the rising edge of clk.
- Reset cycle:
  - rd_data_a, rd_data_b, wr_dropped go to 0; busy goes to 1.
  - Clear counter loads 0; FSM enters CLEAR.
- FSM states:
  - CLEAR: each cycle write 0 to entry[counter], then counter+1. When counter == 2**ADDR_W-1, that entry is cleared and the FSM moves to READY next edge. Busy is high for exactly 2**ADDR_W cycles after reset deasserts.
  - READY: normal operation; busy=0. Stays here until reset.
- Reset asserted mid-CLEAR or in READY: counter restarts at 0, full clear repeats; partial clear progress is discarded.
- Reads during CLEAR:
  - rd_data_a and rd_data_b are forced to 0.
  - Write requests are ignored and wr_dropped pulses 1 the next cycle.
- Reads in READY:
  - Latency 1: the address presented at edge N gives the data on rd_data_x after edge N.
  - Both ports are independent; the same address on A and B is legal and returns the same value.
- Writes in READY: with wr_en=1 at edge N, the entry holds wr_data after edge N.
- Same-cycle read/write to one address:
  - BYPASS=1: rd_data returns wr_data.
  - BYPASS=0: rd_data returns the pre-write contents. This matches the legacy block.
- ZERO_REG=1:
  - Reads of address 0 return 0 regardless of bypass.
  - Writes to 0 leave storage unchanged and pulse wr_dropped.
- ZERO_REG=0: entry 0 is an ordinary register.
- No arithmetic: addresses are unsigned and full range; there is no out-of-range case.
- The counter is ADDR_W bits wide, and the terminal compare is against all-ones, so no wrap beyond depth.
- Outputs never go X after reset; storage is only read after the clear completes or is masked to 0.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants
  - FSM state enum {CLEAR, READY}
  - ZERO_ADDR constant
- Sub-module regfile_clear_seq holds the FSM and the clear counter. It outputs busy, clr_en and clr_addr.
- The top level muxes clear and user writes into the storage array, and handles the read/bypass/zero-mask logic.

Test Plan:
- Reset with defaults, hold reset 1 cycle, release: busy=1 for exactly 16 cycles then 0; every address on A and B then reads 0x0000.
- After clear: write 0xBEEF to addr 5, then 0x1234 to addr 9; next cycle read A=5, B=9 gives rd_data_a=0xBEEF and rd_data_b=0x1234 one cycle later.
- Same-cycle hazard: entry 3 holds 0x1111; write 0x2222 to addr 3 while reading A=3. Expected A=0x2222 with BYPASS=1; A=0x1111 with BYPASS=0; the following read gives 0x2222 in both.
- ZERO_REG=1: write 0xFFFF to addr 0 → wr_dropped=1 next cycle; read addr 0 gives 0x0000 even when read in the same cycle as the write.
- Write during busy at clear cycle 4 (addr 7, 0xAAAA): wr_dropped pulses; after ready, addr 7 reads 0x0000.
- Reset mid-operation: write 0x5A5A to addr 2, assert reset during clear cycle 8 of a second reset sequence; busy stays high a full 16 cycles from release and addr 2 reads 0x0000.
- Parameter sweep DATA_W=32, ADDR_W=5: busy lasts 32 cycles; write 0xDEADBEEF to addr 31 and read it back.
